// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, one-cycle
// readdatavalid / framing_error strobes. Synchronous active-low reset.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] uart_data,
  output logic       readdatavalid,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_param
      $error("uart_byte_rx: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, rxs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Synchroniser resets to the idle (high) level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rxs_q   <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state and strobe logic; strobes default low so each lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = 3'd0;
          if (!rxs_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        // A held-low line must rise before another start bit can be recognised.
        if (rxs_q) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign uart_data     = data_q;
  assign readdatavalid = valid_q;
  assign framing_error = ferr_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 clk per bit: reset, single byte,
// back-to-back, start glitch, framing error/break and mid-frame reset.
module tb_uart_byte_rx;

  localparam int CPB = 16;
  localparam int LAT = 155;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] uart_data;
  logic       readdatavalid;
  logic       framing_error;
  logic       rx_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int both_hi = 0;
  int vq_cyc[$];
  logic [7:0] vq_data[$];
  int fq_cyc[$];

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_in         (rx_in),
    .uart_data     (uart_data),
    .readdatavalid (readdatavalid),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (readdatavalid) begin
      vq_cyc.push_back(cyc);
      vq_data.push_back(uart_data);
    end
    if (framing_error) fq_cyc.push_back(cyc);
    if (readdatavalid && framing_error) both_hi = both_hi + 1;
  end

  // Must be called right at a posedge; drives one full 10-bit frame (160 clk).
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t_fall);
    #1 rx_in = 1'b0;
    t_fall = cyc;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_in = d[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx_in = stop;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic test_reset;
    rx_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({uart_data, readdatavalid, framing_error, rx_busy} !== 11'h000) begin
      n_bad++;
      $display("FAIL reset_idle: got data=%h v=%b fe=%b busy=%b want 00/0/0/0",
               uart_data, readdatavalid, framing_error, rx_busy);
    end
    rx_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({uart_data, readdatavalid, framing_error, rx_busy} !== 11'h000) begin
      n_bad++;
      $display("FAIL reset_rxlow: got data=%h v=%b fe=%b busy=%b want 00/0/0/0",
               uart_data, readdatavalid, framing_error, rx_busy);
    end
    rx_in = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (rx_busy !== 1'b0 || vq_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b pulses=%0d want 0/0", rx_busy, vq_cyc.size());
    end
  endtask

  task automatic test_single_byte;
    int t0;
    int nv;
    nv = vq_cyc.size();
    @(posedge clk);
    send_frame(8'hA5, 1'b1, t0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (vq_cyc.size() != nv + 1) begin
      n_bad++;
      $display("FAIL single_count: got %0d pulses want 1", vq_cyc.size() - nv);
    end else begin
      n_cmp++;
      if (vq_cyc[nv] - t0 != LAT) begin
        n_bad++;
        $display("FAIL single_latency: got %0d want %0d", vq_cyc[nv] - t0, LAT);
      end
      n_cmp++;
      if (vq_data[nv] !== 8'hA5) begin
        n_bad++;
        $display("FAIL single_data: got %h want a5", vq_data[nv]);
      end
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (uart_data !== 8'hA5 || readdatavalid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_hold: data=%h v=%b want a5/0", uart_data, readdatavalid);
    end
  endtask

  task automatic test_back_to_back;
    int ta, tb;
    int nv, nf;
    nv = vq_cyc.size();
    nf = fq_cyc.size();
    @(posedge clk);
    send_frame(8'h31, 1'b1, ta);
    send_frame(8'hF0, 1'b1, tb);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (vq_cyc.size() != nv + 2) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d pulses want 2", vq_cyc.size() - nv);
    end else begin
      n_cmp++;
      if (vq_cyc[nv + 1] - vq_cyc[nv] != 160 || vq_cyc[nv] - ta != LAT) begin
        n_bad++;
        $display("FAIL b2b_spacing: got gap %0d lat %0d want 160/%0d",
                 vq_cyc[nv + 1] - vq_cyc[nv], vq_cyc[nv] - ta, LAT);
      end
      n_cmp++;
      if (vq_data[nv] !== 8'h31 || vq_data[nv + 1] !== 8'hF0) begin
        n_bad++;
        $display("FAIL b2b_data: got %h,%h want 31,f0", vq_data[nv], vq_data[nv + 1]);
      end
    end
    n_cmp++;
    if (fq_cyc.size() != nf) begin
      n_bad++;
      $display("FAIL b2b_ferr: got %0d framing pulses want 0", fq_cyc.size() - nf);
    end
  endtask

  task automatic test_glitch;
    int t0;
    int nv, nf;
    nv = vq_cyc.size();
    nf = fq_cyc.size();
    @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (rx_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_hi: got %b want 1", rx_busy);
    end
    rx_in = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (rx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy_lo: got %b want 0", rx_busy);
    end
    repeat (40) @(posedge clk);
    n_cmp++;
    if (vq_cyc.size() != nv || fq_cyc.size() != nf) begin
      n_bad++;
      $display("FAIL glitch_strobe: got v=%0d fe=%0d want 0/0",
               vq_cyc.size() - nv, fq_cyc.size() - nf);
    end
    send_frame(8'h05, 1'b1, t0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (vq_cyc.size() != nv + 1 || uart_data !== 8'h05) begin
      n_bad++;
      $display("FAIL glitch_next: got pulses=%0d data=%h want 1/05",
               vq_cyc.size() - nv, uart_data);
    end
  endtask

  task automatic test_framing;
    int t0, t1;
    int nv, nf;
    logic [7:0] prev;
    nv = vq_cyc.size();
    nf = fq_cyc.size();
    prev = uart_data;
    @(posedge clk);
    send_frame(8'h42, 1'b0, t0);
    repeat (100) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (fq_cyc.size() != nf + 1) begin
      n_bad++;
      $display("FAIL ferr_count: got %0d framing pulses want 1", fq_cyc.size() - nf);
    end else begin
      n_cmp++;
      if (fq_cyc[nf] - t0 != LAT) begin
        n_bad++;
        $display("FAIL ferr_latency: got %0d want %0d", fq_cyc[nf] - t0, LAT);
      end
    end
    n_cmp++;
    if (vq_cyc.size() != nv || uart_data !== prev) begin
      n_bad++;
      $display("FAIL ferr_nodata: got pulses=%0d data=%h want 0/%h",
               vq_cyc.size() - nv, uart_data, prev);
    end
    @(posedge clk);
    send_frame(8'h07, 1'b1, t1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (vq_cyc.size() != nv + 1 || uart_data !== 8'h07 || fq_cyc.size() != nf + 1) begin
      n_bad++;
      $display("FAIL ferr_recover: got pulses=%0d data=%h fe=%0d want 1/07/1",
               vq_cyc.size() - nv, uart_data, fq_cyc.size() - nf);
    end
  endtask

  task automatic test_reset_midframe;
    int t0, t1;
    int nv, nf;
    nv = vq_cyc.size();
    nf = fq_cyc.size();
    @(posedge clk);
    fork
      send_frame(8'hFF, 1'b1, t0);
      begin
        repeat (CPB + 3 * CPB + 8) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    n_cmp++;
    if (vq_cyc.size() != nv || fq_cyc.size() != nf) begin
      n_bad++;
      $display("FAIL midrst_strobe: got v=%0d fe=%0d want 0/0",
               vq_cyc.size() - nv, fq_cyc.size() - nf);
    end
    send_frame(8'h12, 1'b1, t1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (vq_cyc.size() != nv + 1 || uart_data !== 8'h12) begin
      n_bad++;
      $display("FAIL midrst_next: got pulses=%0d data=%h want 1/12",
               vq_cyc.size() - nv, uart_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    n_cmp++;
    if (both_hi != 0) begin
      n_bad++;
      $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", both_hi);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
Serial receive front end for the cube controller. Samples the asynchronous host UART line (8N1, LSB first) and recovers bytes. Each good byte is presented on uart_data with a one-cycle readdatavalid strobe. uart_data drives the controller's uart_in and readdatavalid drives its readdatavalid, which feed the config space and the multi-frame engine. Framing faults are flagged and never delivered as data.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4, elaboration error otherwise.
HALF_BIT, CLKS_PER_BIT/2 (integer division), cycles from start-bit detection to the start-bit mid-sample.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rx_in  in  1  asynchronous serial line; idle high
uart_data  out  8  last good received byte
readdatavalid  out  1  one-cycle strobe; uart_data is new and valid this cycle
framing_error  out  1  one-cycle strobe; stop bit sampled low
rx_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst_n synchronous, active-low, on clk rising edge. Resets: both synchroniser flops to 1; state IDLE; counters 0. Outputs: uart_data 8'h00, readdatavalid 0, framing_error 0, rx_busy 0. Reset mid-frame abandons the frame with no strobe. The next byte is accepted only after a fresh high-to-low transition.
- Synchroniser: 2-flop on rx_in. All logic uses the second flop output (rxs). Latency is 2 clk.
- Bit counter cnt: width clog2(CLKS_PER_BIT). Bit index 0..7. 8-bit shift register; bits enter at MSB and shift right, so bit 0 lands in LSB.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rxs==0 -> START, cnt<=0. Define this cycle as t0.
- START: cnt increments each cycle. When cnt==HALF_BIT-1, sample rxs at t0+HALF_BIT.
  - rxs==0: go to DATA, cnt<=0, bit index<=0.
  - rxs==1: glitch; go to IDLE with no strobe.
- DATA: when cnt==CLKS_PER_BIT-1, sample rxs into the shift register and reset cnt.
  - Sample k (k=1..8) occurs at t0+HALF_BIT+k*CLKS_PER_BIT.
  - After the 8th sample, go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, the stop bit is sampled at t0+HALF_BIT+9*CLKS_PER_BIT.
  - rxs==1: uart_data<=shift register, readdatavalid=1 in the next cycle only, go to IDLE.
  - rxs==0: framing_error=1 in the next cycle only, uart_data unchanged, go to BREAK.
- BREAK: wait until rxs==1, then go to IDLE. A held-low line (break) yields exactly one framing_error and no further strobes.
- Back-to-back frames: the next start bit may begin immediately after the stop-bit mid-sample. Returning to IDLE after the stop sample lets a falling edge half a bit later be caught.
- readdatavalid and framing_error are never high together. Each is at most one cycle per frame.
- uart_data holds its value between strobes. No backpressure: the consumer must accept each byte in its strobe cycle.
- rx_busy is combinational from state (state != IDLE).

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8, bit period 16 clk):
- Reset: rx_in=1, rst_n low 3 cycles → all outputs 0, rx_busy 0. Assert rst_n low while rx_in=0 → outputs remain 0.
- Single byte 8'hA5, 8N1 → exactly one readdatavalid pulse. Pulse lands 2+8+9*16+1=155 clk after the rx_in falling edge (±0). uart_data==8'hA5 and held afterwards.
- Back-to-back 8'h31, 8'hF0 with zero idle gap → two pulses 160 clk apart, data 8'h31 then 8'hF0. framing_error stays 0.
- Start glitch: rx_in low 5 clk then high → no strobe, rx_busy returns 0 by t0+9.
  - A following 8'h05 is received correctly.
- Framing error: 8'h42 with stop bit 0, line held low 100 clk, then 8'h07 → one framing_error pulse, no readdatavalid for the bad frame, uart_data unchanged.
  - 8'h07 is then delivered correctly.
- Reset mid-frame: assert rst_n low during data bit 3 of 8'hFF → no strobe. Next frame 8'h12 → one pulse, uart_data==8'h12.
